// File: rtl/fp2ieee_stream.sv
// Streaming converter from the FloPoCo internal floating-point format to IEEE 754.
// S1 decodes the exception field and denormalises exponent-0 values; S2 rounds and packs.
module fp2ieee_stream #(
    parameter int DataWidth = 32,
    parameter int ExpWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [DataWidth+1:0] fp_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] ieee_o,
    output logic [2:0]           flags_o,
    output logic                 valid_o,
    input  logic                 ready_i
);
    localparam int FracWidth = DataWidth - 1 - ExpWidth;
    localparam int ShiftAmt  = 1;
    localparam int ExtWidth  = FracWidth + 2;

    localparam logic [1:0]           ExnZero   = 2'b00;
    localparam logic [1:0]           ExnNormal = 2'b01;
    localparam logic [1:0]           ExnInf    = 2'b10;
    localparam logic [1:0]           ExnNan    = 2'b11;
    localparam logic [ExpWidth-1:0]  ExpOnes   = {ExpWidth{1'b1}};
    localparam logic [ExpWidth-1:0]  ExpZero   = {ExpWidth{1'b0}};
    localparam logic [FracWidth-1:0] FracZero  = {FracWidth{1'b0}};
    localparam logic [FracWidth-1:0] QnanFrac  = {1'b1, {(FracWidth-1){1'b0}}};
    // Bits of the extended significand that fall below the guard position.
    localparam logic [ExtWidth-1:0]  StickyMask = ~({ExtWidth{1'b1}} << ShiftAmt);

    logic                 v1_q, v2_q;
    logic                 en1_s, en2_s, ld1_s, ld2_s;

    logic [1:0]           exn_s;
    logic                 sign_in_s;
    logic [ExpWidth-1:0]  exp_in_s;
    logic [FracWidth-1:0] frac_in_s;
    logic [ExtWidth-1:0]  ext_s;
    logic [FracWidth:0]   shifted_s;

    logic                 sign_d, sign_q;
    logic [ExpWidth-1:0]  exp_d, exp_q;
    logic [FracWidth-1:0] frac_d, frac_q;
    logic                 guard_d, guard_q;
    logic                 sticky_d, sticky_q;
    logic                 den_d, den_q;
    logic                 ovf_d, ovf_q;

    logic                 inc_s;
    logic                 inexact_s;
    logic [FracWidth:0]   sum_s;
    logic [DataWidth-1:0] ieee_d, ieee_q;
    logic [2:0]           flags_d, flags_q;

    assign en2_s   = !v2_q || ready_i;
    assign en1_s   = !v1_q || en2_s;
    assign ready_o = en1_s;
    assign ld1_s   = en1_s && valid_i && !flush_i;
    assign ld2_s   = en2_s && v1_q && !flush_i;

    assign exn_s     = fp_i[DataWidth+1:DataWidth];
    assign sign_in_s = fp_i[DataWidth-1];
    assign exp_in_s  = fp_i[DataWidth-2:FracWidth];
    assign frac_in_s = fp_i[FracWidth-1:0];

    // Hidden one, fraction and a pad bit; after the shift bit 0 is the guard.
    assign ext_s     = {1'b1, frac_in_s, 1'b0};
    assign shifted_s = (FracWidth+1)'(ext_s >> ShiftAmt);

    // S1 decode: classify the operand and produce the unrounded IEEE fields.
    always_comb begin
        sign_d   = sign_in_s;
        exp_d    = ExpZero;
        frac_d   = FracZero;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        den_d    = 1'b0;
        ovf_d    = 1'b0;
        case (exn_s)
            ExnZero: begin
                exp_d  = ExpZero;
                frac_d = FracZero;
            end
            ExnInf: begin
                exp_d  = ExpOnes;
                frac_d = FracZero;
            end
            ExnNan: begin
                sign_d = 1'b0;
                exp_d  = ExpOnes;
                frac_d = QnanFrac;
            end
            ExnNormal: begin
                if (exp_in_s == ExpOnes) begin
                    exp_d = ExpOnes;
                    ovf_d = 1'b1;
                end else if (exp_in_s == ExpZero) begin
                    frac_d   = shifted_s[FracWidth:1];
                    guard_d  = shifted_s[0];
                    sticky_d = |(ext_s & StickyMask);
                    den_d    = 1'b1;
                end else begin
                    exp_d  = exp_in_s;
                    frac_d = frac_in_s;
                end
            end
            default: begin
                exp_d  = ExpZero;
                frac_d = FracZero;
            end
        endcase
    end

    assign inc_s     = den_q && guard_q && (frac_q[0] || sticky_q);
    assign inexact_s = guard_q || sticky_q;
    assign sum_s     = {1'b0, frac_q} + {{FracWidth{1'b0}}, inc_s};

    // S2 round/pack: a carry out of the fraction lands in the exponent LSB (min normal).
    always_comb begin
        ieee_d  = {sign_q, exp_q, frac_q};
        flags_d = 3'b000;
        if (ovf_q) begin
            flags_d = 3'b101;
        end else if (den_q) begin
            ieee_d  = {sign_q, {(ExpWidth-1){1'b0}}, sum_s[FracWidth], sum_s[FracWidth-1:0]};
            flags_d = {1'b0, inexact_s && !sum_s[FracWidth], inexact_s};
        end else begin
            ieee_d  = {sign_q, exp_q, frac_q};
            flags_d = 3'b000;
        end
    end

    // Stage valid bits; flush has priority over any accept or advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (flush_i) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (en1_s) v1_q <= valid_i;
            if (en2_s) v2_q <= v1_q;
        end
    end

    // S1 payload register, loaded on input transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sign_q   <= 1'b0;
            exp_q    <= ExpZero;
            frac_q   <= FracZero;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            den_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (ld1_s) begin
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            frac_q   <= frac_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            den_q    <= den_d;
            ovf_q    <= ovf_d;
        end
    end

    // S2 output register, held while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ieee_q  <= {DataWidth{1'b0}};
            flags_q <= 3'b000;
        end else if (ld2_s) begin
            ieee_q  <= ieee_d;
            flags_q <= flags_d;
        end
    end

    assign ieee_o  = ieee_q;
    assign flags_o = flags_q;
    assign valid_o = v2_q;

endmodule

// File: tb/tb_fp2ieee_stream.sv
// Scoreboard bench for fp2ieee_stream: directed table items plus random operands
// checked against an arithmetic reference model.
module tb_fp2ieee_stream;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni, flush_i, valid_i, ready_i;
    logic [DW+1:0] fp_i;
    logic          ready_o, valid_o;
    logic [DW-1:0] ieee_o;
    logic [2:0]    flags_o;

    fp2ieee_stream #(.DataWidth(32), .ExpWidth(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .fp_i(fp_i),
        .valid_i(valid_i), .ready_o(ready_o), .ieee_o(ieee_o), .flags_o(flags_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] ieee;
        logic [2:0]  flags;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int          cyc      = 0;
    bit          use_dir  = 1'b0;
    bit          chk_lat  = 1'b0;
    bit          rand_rdy = 1'b0;
    logic [31:0] dir_ieee = 32'd0;
    logic [2:0]  dir_flags = 3'd0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [33:0] mk(input logic [1:0] exn, input logic s,
                                       input logic [7:0] e, input logic [22:0] f);
        return {exn, s, e, f};
    endfunction

    // Value-level model: halve the significand, round half to even, classify.
    function automatic logic [34:0] ref_model(input logic [33:0] fp);
        logic [1:0]  exn;
        logic        s;
        int unsigned e, f, m, q, r;
        logic [31:0] res;
        logic [2:0]  fl;
        exn = fp[33:32];
        s   = fp[31];
        e   = fp[30:23];
        f   = fp[22:0];
        fl  = 3'b000;
        res = 32'd0;
        case (exn)
            2'b00: res = {s, 31'd0};
            2'b10: res = {s, 8'hFF, 23'd0};
            2'b11: res = 32'h7FC0_0000;
            default: begin
                if (e == 255) begin
                    res = {s, 8'hFF, 23'd0};
                    fl  = 3'b101;
                end else if (e == 0) begin
                    m = 32'h0080_0000 + f;
                    q = m / 2;
                    r = m % 2;
                    if (r == 1 && (q % 2) == 1) q = q + 1;
                    res   = {s, q[30:0]};
                    fl[0] = (r != 0);
                    fl[1] = (r != 0) && (q < 32'h0080_0000);
                end else begin
                    res = fp[31:0];
                end
            end
        endcase
        return {fl, res};
    endfunction

    function automatic logic [33:0] rand_fp();
        int          r, k;
        logic [1:0]  exn;
        logic [7:0]  e;
        logic [22:0] f;
        r   = $urandom_range(0, 9);
        exn = (r < 6) ? 2'b01 : 2'(r - 6);
        k   = $urandom_range(0, 3);
        e   = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom);
        f   = 23'($urandom);
        return {exn, 1'($urandom), e, f};
    endfunction

    // Input capture: push the expected response for every accepted item.
    always @(negedge clk_i) begin : capture
        exp_t        ex;
        logic [34:0] mr;
        if (rst_ni) begin
            if (flush_i) begin
                sb_q.delete();
            end else if (valid_i && ready_o) begin
                mr       = ref_model(fp_i);
                ex.ieee  = use_dir ? dir_ieee : mr[31:0];
                ex.flags = use_dir ? dir_flags : mr[34:32];
                ex.acc   = cyc;
                ex.lat   = chk_lat;
                sb_q.push_back(ex);
            end
        end
    end

    // Output monitor: pop and compare on each output transfer; check stall stability.
    always @(negedge clk_i) begin : monitor
        static bit          stall_prev = 1'b0;
        static bit          flush_prev = 1'b0;
        static logic [34:0] held = 35'd0;
        exp_t               ex;
        if (!rst_ni) begin
            stall_prev = 1'b0;
            flush_prev = 1'b0;
        end else begin
            if (stall_prev && !flush_prev) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", {flags_o, ieee_o}, held);
            end
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h, expected no output", ieee_o);
                end else begin
                    ex = sb_q.pop_front();
                    check("result", {flags_o, ieee_o}, {ex.flags, ex.ieee});
                    if (ex.lat) check("latency", cyc - ex.acc, 2);
                    n_out++;
                end
            end
            stall_prev = valid_o && !ready_i;
            flush_prev = flush_i;
            held       = {flags_o, ieee_o};
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic present(input logic [33:0] fp, input bit dir,
                           input logic [31:0] ei, input logic [2:0] ef);
        fp_i      = fp;
        valid_i   = 1'b1;
        use_dir   = dir;
        dir_ieee  = ei;
        dir_flags = ef;
    endtask

    task automatic send(input logic [33:0] fp, input bit dir,
                        input logic [31:0] ei, input logic [2:0] ef);
        int t;
        bit acc;
        t = 0;
        present(fp, dir, ei, ef);
        do begin
            @(negedge clk_i);
            acc = ready_o;
            tick();
            t++;
        end while (!acc && t < 200);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        int n0;
        rst_ni  = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        fp_i    = '0;
        #2 rst_ni = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_ieee", ieee_o, 0);
        check("rst_flags", flags_o, 0);
        check("rst_ready", ready_o, 1);
        repeat (2) tick();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();

        // Directed conversions with ready_i high and latency checking.
        chk_lat = 1'b1;
        send(mk(2'b01, 1'b0, 8'h7F, 23'h0), 1, 32'h3F80_0000, 3'b000);
        send(mk(2'b00, 1'b1, 8'($urandom), 23'($urandom)), 1, 32'h8000_0000, 3'b000);
        send(mk(2'b10, 1'b1, 8'($urandom), 23'($urandom)), 1, 32'hFF80_0000, 3'b000);
        send(mk(2'b11, 1'b1, 8'($urandom), 23'($urandom)), 1, 32'h7FC0_0000, 3'b000);
        send(mk(2'b01, 1'b0, 8'h00, 23'h000000), 1, 32'h0040_0000, 3'b000);
        send(mk(2'b01, 1'b0, 8'h00, 23'h000001), 1, 32'h0040_0000, 3'b011);
        send(mk(2'b01, 1'b0, 8'h00, 23'h7FFFFF), 1, 32'h0080_0000, 3'b001);
        send(mk(2'b01, 1'b1, 8'hFF, 23'h123456), 1, 32'hFF80_0000, 3'b101);
        valid_i = 1'b0;
        drain();
        chk_lat = 1'b0;

        // Backpressure: A and B fill the pipe, C stalls until ready_i rises.
        n0 = n_out;
        ready_i = 1'b0;
        send(mk(2'b01, 1'b0, 8'h7F, 23'h0), 1, 32'h3F80_0000, 3'b000);
        send(mk(2'b01, 1'b1, 8'hFF, 23'h123456), 1, 32'hFF80_0000, 3'b101);
        present(mk(2'b01, 1'b0, 8'h00, 23'h000001), 1, 32'h0040_0000, 3'b011);
        repeat (4) begin
            @(negedge clk_i);
            check("bp_ready_low", ready_o, 0);
            check("bp_valid", valid_o, 1);
            check("bp_hold_a", {flags_o, ieee_o}, {3'b000, 32'h3F80_0000});
            tick();
        end
        ready_i = 1'b1;
        send(mk(2'b01, 1'b0, 8'h00, 23'h000001), 1, 32'h0040_0000, 3'b011);
        valid_i = 1'b0;
        drain();
        check("bp_count", n_out - n0, 3);

        // Flush with both stages full and a new item presented.
        ready_i = 1'b0;
        send(rand_fp(), 0, 32'd0, 3'd0);
        send(rand_fp(), 0, 32'd0, 3'd0);
        present(rand_fp(), 0, 32'd0, 3'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        check("flush_valid", valid_o, 0);
        check("flush_ready", ready_o, 1);
        n0 = n_out;
        ready_i = 1'b1;
        repeat (4) tick();
        check("flush_no_output", n_out - n0, 0);

        // Asynchronous reset between edges with both stages full.
        ready_i = 1'b0;
        send(mk(2'b01, 1'b0, 8'h7F, 23'h0), 1, 32'h3F80_0000, 3'b000);
        send(mk(2'b01, 1'b0, 8'h80, 23'h1), 1, 32'h4000_0001, 3'b000);
        valid_i = 1'b0;
        #3 rst_ni = 1'b0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_ieee", ieee_o, 0);
        sb_q.delete();
        tick();
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        tick();

        // 100 random operands back to back, latency 2.
        chk_lat = 1'b1;
        for (int i = 0; i < 100; i++) send(rand_fp(), 0, 32'd0, 3'd0);
        valid_i = 1'b0;
        drain();
        chk_lat = 1'b0;

        // Random operands with random gaps and random downstream stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                tick();
            end
            send(rand_fp(), 0, 32'd0, 3'd0);
        end
        valid_i  = 1'b0;
        rand_rdy = 1'b0;
        ready_i  = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp2ieee_stream.md
Name: fp2ieee_stream

Overview:
- Pipelined converter from FloPoCo internal floating-point format to IEEE 754 binary format; the reverse direction of the IEEE-to-FloPoCo input path used by the IEEE compare and arithmetic wrappers.
- Sits at the output of FloPoCo datapaths and streams results back to IEEE consumers over a valid/ready interface.
- Handles denormalisation of FloPoCo exponent-0 values with round-to-nearest-even, overflow of exponent all-ones values, and NaN canonicalisation.

Parameters:
- DataWidth, 32, IEEE word width.
- ExpWidth, 8, exponent width. FracWidth is derived as DataWidth-1-ExpWidth and must not be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous clear of all in-flight items
- fp_i  in  DataWidth+2  FloPoCo operand {exn[1:0], sign, exp, frac}; exn: 00 zero, 01 normal, 10 inf, 11 NaN
- valid_i  in  1  input valid
- ready_o  out  1  input ready
- ieee_o  out  DataWidth  IEEE result {sign, exp, frac}
- flags_o  out  3  {overflow, underflow, inexact}, aligned with ieee_o
- valid_o  out  1  output valid
- ready_i  in  1  downstream ready

Behaviour:
- Reset: valid_o=0, ieee_o=0, flags_o=0, all internal stage-valid bits cleared. Reset asserted mid-transfer discards every in-flight item; no output is produced for them.
- Pipeline: two register stages (S1 decode/shift, S2 round/pack). Latency is exactly 2 cycles with ready_i held high. Throughput is 1 item per cycle.
- Handshake:
  - en2 = !v2 || ready_i; en1 = !v1 || en2; ready_o = en1.
  - ready_o depends combinationally on ready_i; this path is permitted.
  - A transfer occurs when valid && ready are both high in the same cycle.
  - While valid_o=1 && ready_i=0, ieee_o and flags_o are held stable.
  - valid_o never deasserts without a handshake, except on flush_i or reset.
- flush_i: on the next edge v1 and v2 clear. An input presented in the flush cycle is dropped. flush_i has priority over simultaneous accept.
- Conversion rules:
  - exn=00: result {s, 0, 0}; flags 0.
  - exn=10: result {s, all-ones, 0}; flags 0.
  - exn=11: canonical quiet NaN {0, all-ones, 1 followed by zeros}, sign forced to 0; flags 0.
  - exn=01, 0 < exp < all-ones: result {s, exp, frac} passed through unchanged; flags 0.
  - exn=01, exp=all-ones: overflow to {s, all-ones, 0}; overflow=1, inexact=1.
  - exn=01, exp=0: significand {1, frac} shifted right 1. Guard = shifted-out bit; sticky = 0.
    - Round to nearest even: increment if guard && (lsb || sticky).
    - A carry into bit FracWidth yields exp field 1 with frac 0, which is the minimum normal.
    - inexact = guard. underflow = inexact && result still subnormal, i.e. tininess is detected after rounding.
- The shift amount is fixed at 1, but S1 must compute guard/sticky generically from a (FracWidth+2)-bit shifted vector.
- Simultaneous input accept and output drain in the same cycle is legal and must not stall.

Test Plan:
All values for DataWidth=32. fp_i is written as exn|s|exp|frac.
1. Normal passthrough: 01|0|0x7F|0 -> ieee_o=0x3F800000, flags=000, valid_o exactly 2 cycles after the accept with ready_i=1. Then 00|1|x|x -> 0x80000000; 10|1|x|x -> 0xFF800000; 11|1|x|x -> 0x7FC00000.
2. Denormalisation:
   - 01|0|0x00|0 -> 0x00400000, flags=000.
   - 01|0|0x00|0x000001 -> 0x00400000 (tie, stays even), flags=011.
   - 01|0|0x00|0x7FFFFF -> 0x00800000 (rounds to min normal), flags=001.
3. Overflow: 01|1|0xFF|0x123456 -> 0xFF800000, flags=101.
4. Backpressure: ready_i=0 for 6 cycles while valid_i=1 with items A,B,C. A and B are accepted; ready_o=0 while C is presented. ieee_o=A is held stable. Raising ready_i drains A, B, C in order, one per cycle, with no loss or duplication.
5. Flush: fill both stages with ready_i=0, pulse flush_i together with valid_i=1 -> next cycle valid_o=0, ready_o=1; the flushed and presented items never appear at the output.
6. Reset mid-operation: assert rst_ni=0 asynchronously between edges with both stages full -> valid_o=0 and ieee_o=0 immediately. After release, a streamed back-to-back sequence of 100 random operands matches the reference model with latency 2.
